sysid_checker: RTL and testbench
================================

Name: sysid_checker

Overview:
- Avalon-MM master that sits directly upstream of the system-ID slave and consumes its two readdata words.
  - Address 0 holds the system ID; address 1 holds the build timestamp.
- Reads both words automatically after reset, and again on request.
- Compares each word against expected build-time values and reports pass, mismatch or bus timeout.
- Status levels and captured words drive the board status LEDs and host-visible status; firmware-independent check that the loaded image matches the expected build.

Parameters:
- EXPECTED_ID, 1478765543: expected word at address 0.
- EXPECTED_TS, 1309222362: expected word at address 1.
- READ_LATENCY, 1: fixed slave read latency in cycles after read accepted; legal 0..3.
- TIMEOUT_CYCLES, 255: maximum waitrequest-high cycles per read before abort; 8-bit counter, legal 1..255.
- RECHECK_INTERVAL, 1000000: cycles between automatic rechecks; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request for a new check
- avm_address  out  1  word select: 0 = ID, 1 = timestamp
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  slave read data
- busy  out  1  check in progress
- done  out  1  level, results valid
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TS
- mismatch  out  1  done and not (id_ok and ts_ok) and not timeout
- timeout  out  1  last check aborted on waitrequest
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

Behaviour:
- Reset (asynchronous, reset_n low) clears all outputs to 0 and forces IDLE.
- The auto-start flag sets on reset, so one check starts without a start pulse.
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CMP, DONE.
- IDLE -> RD_ID when the auto-start flag or start is set. Clear the flag, done, id_ok, ts_ok, mismatch and timeout; set busy.
- RD_ID / RD_TS:
  - Drive avm_read=1 and avm_address=0 or 1, held stable while avm_waitrequest=1.
  - Read is accepted on a clk edge with avm_waitrequest=0.
  - On accept, avm_read drops on the next edge.
  - READ_LATENCY=0: capture avm_readdata on the accepting edge and go straight to the next RD state or CMP.
  - READ_LATENCY>0: go to WAIT_ID / WAIT_TS.
- WAIT_ID / WAIT_TS: avm_read=0; stay READ_LATENCY cycles, capture avm_readdata on the last cycle's edge, then go to RD_TS or CMP.
- CMP: id_ok = (id_value==EXPECTED_ID), ts_ok = (ts_value==EXPECTED_TS); next edge enters DONE.
- DONE:
  - busy=0, done=1; mismatch is valid.
  - Hold all results until the next start, which re-enters RD_ID with status cleared.
- Latency: with zero wait states, done rises 4+2*READ_LATENCY edges after the edge that leaves IDLE.
- Timeout:
  - An 8-bit counter clears on entry to each RD state and increments each cycle avm_read=1 with avm_waitrequest=1.
  - When it reaches TIMEOUT_CYCLES, drop avm_read and go to DONE with timeout=1, id_ok=0, ts_ok=0, mismatch=0.
  - id_value / ts_value keep whatever was captured so far; uncaptured words read 0.
- start while busy=1 is ignored; start is not queued.
- Reset mid-check: asynchronous abort; all outputs return to 0 and a fresh auto check follows.
- Captures are full 32-bit; the comparison is an exact 32-bit equality.

Optional Feature:
- Macro SYSID_CHECKER_PERIODIC_EN.
- Defined:
  - A 32-bit interval counter runs while in DONE.
  - At RECHECK_INTERVAL cycles it sets the auto-start flag, re-running the check exactly as a start pulse does.
  - The counter clears on leaving DONE and on reset.
  - A start pulse in DONE takes effect immediately and clears the counter.
- Not defined: no interval counter; checks run only after reset and on start.

Test Plan:
- Reset release, slave model latency 1, no waitrequest, words 1478765543/1309222362 -> done=1 at edge 6 after IDLE exit; id_ok=1, ts_ok=1, mismatch=0, avm_address sequence 0 then 1.
- Slave returns timestamp 0x00000000 -> done=1, id_ok=1, ts_ok=0, mismatch=1, ts_value=0.
- waitrequest stuck high on the address-1 read -> after 255 stalled cycles avm_read drops, timeout=1, mismatch=0, id_value=1478765543, ts_value=0.
- READ_LATENCY=0 and =3 builds, 2 wait states per read -> correct capture, done at 4+2L+4 edges after IDLE exit.
- start pulsed during busy, then again in DONE -> first ignored, second clears status and repeats reads; reset_n low mid-WAIT_TS -> all outputs 0 asynchronously, fresh check on release.
- With SYSID_CHECKER_PERIODIC_EN, RECHECK_INTERVAL=100 -> busy re-rises 100 cycles after each done; without the macro, busy stays 0 for 1000 cycles.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the system-ID slave (ID word at address 0,
//   build timestamp at address 1) after reset and on start, then compares both words against build-time constants.
// Latency: done rises 4+2*READ_LATENCY edges after the edge that leaves IDLE, plus any slave wait states.
// Backpressure: avm_read/avm_address are held while avm_waitrequest is high; a read stalled for
//   TIMEOUT_CYCLES cycles is abandoned and the check ends with timeout=1.
//
// Optional feature: define SYSID_CHECKER_PERIODIC_EN to re-run the check every RECHECK_INTERVAL
//   cycles spent in DONE. Without it, checks run only after reset and on start.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   start                 one-cycle request for a new check (ignored while busy)
//   avm_address/avm_read  Avalon-MM read request (0 = ID, 1 = timestamp)
//   avm_waitrequest       slave stall
//   avm_readdata          slave read data, valid READ_LATENCY cycles after accept
//   busy, done            check in progress / results valid (levels)
//   id_ok, ts_ok          captured word equals the expected constant
//   mismatch, timeout     check finished with a wrong word / aborted on a stalled read
//   id_value, ts_value    captured words (0 when not captured in the last check)

module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID      = 32'd1478765543,
  parameter logic [31:0] EXPECTED_TS      = 32'd1309222362,
  parameter int          READ_LATENCY     = 1,
  parameter int          TIMEOUT_CYCLES   = 255,
  parameter int          RECHECK_INTERVAL = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // Stall count at which a further stalled cycle hits the limit.
  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT_CYCLES - 1);
  // Index of the final wait cycle; unused when READ_LATENCY is 0.
  localparam logic [1:0] LAT_LAST   = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    CMP,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        auto_start;
  logic [7:0]  stall_cnt;
  logic [1:0]  lat_cnt;
  logic        rd_phase;
  logic        accept;
  logic        stall_abort;
  logic        lat_last;
  logic        cap_id;
  logic        cap_ts;
  logic        check_go;
  logic        recheck;

  assign rd_phase    = (state == RD_ID) || (state == RD_TS);
  assign accept      = rd_phase && !avm_waitrequest;
  // The stall that would bring the counter to TIMEOUT_CYCLES ends the read.
  assign stall_abort = rd_phase && avm_waitrequest && (stall_cnt == STALL_LAST);
  assign lat_last    = (lat_cnt == LAT_LAST);

  // Request outputs are decoded from the registered state, so they are
  // glitch-free and stay stable for the whole stall.
  assign avm_read    = rd_phase;
  assign avm_address = (state == RD_TS);

`ifdef SYSID_CHECKER_PERIODIC_EN
  localparam logic [31:0] INTERVAL_LAST = 32'(RECHECK_INTERVAL - 1);

  logic [31:0] interval_cnt;

  // Counts settled DONE cycles; any exit from DONE (including a start pulse)
  // clears it so the interval restarts from the next result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      interval_cnt <= '0;
    end else if ((state == DONE) && done && (state_nxt == DONE)) begin
      interval_cnt <= interval_cnt + 32'd1;
    end else begin
      interval_cnt <= '0;
    end
  end

  // Acts as the auto-start request: re-runs the check exactly like start.
  assign recheck = (state == DONE) && done && (interval_cnt == INTERVAL_LAST);
`else
  assign recheck = 1'b0;
`endif

  // Next-state and capture strobes.
  always_comb begin
    state_nxt = state;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    case (state)
      IDLE: begin
        if (auto_start || start) begin
          state_nxt = RD_ID;
        end
      end
      RD_ID: begin
        if (stall_abort) begin
          state_nxt = DONE;
        end else if (accept) begin
          if (READ_LATENCY == 0) begin
            // Zero-latency slave: data is on the bus at the accepting edge.
            cap_id    = 1'b1;
            state_nxt = RD_TS;
          end else begin
            state_nxt = WAIT_ID;
          end
        end
      end
      WAIT_ID: begin
        if (lat_last) begin
          cap_id    = 1'b1;
          state_nxt = RD_TS;
        end
      end
      RD_TS: begin
        if (stall_abort) begin
          state_nxt = DONE;
        end else if (accept) begin
          if (READ_LATENCY == 0) begin
            cap_ts    = 1'b1;
            state_nxt = CMP;
          end else begin
            state_nxt = WAIT_TS;
          end
        end
      end
      WAIT_TS: begin
        if (lat_last) begin
          cap_ts    = 1'b1;
          state_nxt = CMP;
        end
      end
      CMP: begin
        state_nxt = DONE;
      end
      DONE: begin
        // The first DONE cycle is still busy and settles the result flags;
        // requests are honoured only once done is visible.
        if (done && (start || recheck)) begin
          state_nxt = RD_ID;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign check_go = (state_nxt == RD_ID) && ((state == IDLE) || (state == DONE));

  // State register plus stall and latency counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      stall_cnt <= '0;
      lat_cnt   <= '0;
    end else begin
      state <= state_nxt;

      // Counts stalled cycles of the current read; any accepted read or
      // non-read state restarts it, covering back-to-back zero-latency reads.
      if (rd_phase && avm_waitrequest) begin
        stall_cnt <= stall_cnt + 8'd1;
      end else begin
        stall_cnt <= '0;
      end

      if ((state == WAIT_ID) || (state == WAIT_TS)) begin
        lat_cnt <= lat_cnt + 2'd1;
      end else begin
        lat_cnt <= '0;
      end
    end
  end

  // Status, captured words and the auto-start flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_start <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      id_ok      <= 1'b0;
      ts_ok      <= 1'b0;
      mismatch   <= 1'b0;
      timeout    <= 1'b0;
      id_value   <= '0;
      ts_value   <= '0;
    end else if (check_go) begin
      // Captures are cleared as well so a word that is never read shows 0.
      auto_start <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      id_ok      <= 1'b0;
      ts_ok      <= 1'b0;
      mismatch   <= 1'b0;
      timeout    <= 1'b0;
      id_value   <= '0;
      ts_value   <= '0;
    end else begin
      if (cap_id) begin
        id_value <= avm_readdata;
      end
      if (cap_ts) begin
        ts_value <= avm_readdata;
      end
      if (state == CMP) begin
        id_ok <= (id_value == EXPECTED_ID);
        ts_ok <= (ts_value == EXPECTED_TS);
      end
      if (stall_abort) begin
        timeout <= 1'b1;
      end
      if ((state == DONE) && !done) begin
        done     <= 1'b1;
        busy     <= 1'b0;
        mismatch <= !(id_ok && ts_ok) && !timeout;
      end
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed bench for sysid_checker.
// Latency: n/a (bench); three DUTs with READ_LATENCY 1 (main), 0 and 3 (2 wait states per read).
// Backpressure: slave models drive avm_waitrequest from a per-read wait-state count or a stuck flag.

module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd1478765543;
  localparam logic [31:0] EXP_TS = 32'd1309222362;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  logic        start_s [3];
  logic        addr_s  [3];
  logic        rd_s    [3];
  logic        wreq_s  [3];
  logic [31:0] rdat_s  [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic        idok_s  [3];
  logic        tsok_s  [3];
  logic        mm_s    [3];
  logic        to_s    [3];
  logic [31:0] idv_s   [3];
  logic [31:0] tsv_s   [3];

  logic [31:0] mem_id   [3];
  logic [31:0] mem_ts   [3];
  logic [7:0]  ws_n     [3];
  logic        stuck_ts [3];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    localparam int LI  = (LAT == 0) ? 0 : LAT - 1;

    logic [7:0]  wcnt;
    logic [2:0]  pvld;
    logic [31:0] pdat [3];
    logic [31:0] word_now;
    int          be;

    sysid_checker #(
      .EXPECTED_ID      (EXP_ID),
      .EXPECTED_TS      (EXP_TS),
      .READ_LATENCY     (LAT),
      .TIMEOUT_CYCLES   (255),
      .RECHECK_INTERVAL (100)
    ) u_dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start_s[g]),
      .avm_address     (addr_s[g]),
      .avm_read        (rd_s[g]),
      .avm_waitrequest (wreq_s[g]),
      .avm_readdata    (rdat_s[g]),
      .busy            (busy_s[g]),
      .done            (done_s[g]),
      .id_ok           (idok_s[g]),
      .ts_ok           (tsok_s[g]),
      .mismatch        (mm_s[g]),
      .timeout         (to_s[g]),
      .id_value        (idv_s[g]),
      .ts_value        (tsv_s[g])
    );

    // Slave model: ws_n wait states at the start of every read, optional
    // permanent stall on address 1, data returned LAT cycles after accept.
    assign wreq_s[g] = rd_s[g] && ((stuck_ts[g] && addr_s[g]) || (wcnt < ws_n[g]));
    assign word_now  = addr_s[g] ? mem_ts[g] : mem_id[g];
    assign rdat_s[g] = (LAT == 0) ? ((rd_s[g] && !wreq_s[g]) ? word_now : 32'hDEADBEEF)
                                  : (pvld[LI] ? pdat[LI] : 32'hDEADBEEF);

    always @(posedge clk) begin
      if (rd_s[g] && !wreq_s[g]) begin
        wcnt <= 8'd0;
      end else if (rd_s[g]) begin
        wcnt <= wcnt + 8'd1;
      end else begin
        wcnt <= 8'd0;
      end
      pvld    <= {pvld[1:0], rd_s[g] && !wreq_s[g]};
      pdat[0] <= word_now;
      pdat[1] <= pdat[0];
      pdat[2] <= pdat[1];
    end

    // Edges whose pre-edge busy is high: from the IDLE exit up to the done edge.
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        be <= 0;
      end else if (busy_s[g]) begin
        be <= be + 1;
      end
    end
  end

  // Main-instance bus monitor: accepted reads, their addresses, stalled address-1 cycles.
  int         acc_cnt   = 0;
  int         stall_cnt = 0;
  logic [7:0] addr_seq  = 8'd0;

  always @(posedge clk) begin
    if (rd_s[0] && !wreq_s[0]) begin
      acc_cnt  <= acc_cnt + 1;
      addr_seq <= {addr_seq[6:0], addr_s[0]};
    end
    if (rd_s[0] && wreq_s[0] && addr_s[0]) begin
      stall_cnt <= stall_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic b, input logic d, input logic io,
                            input logic tk, input logic mm, input logic tmo,
                            input logic [31:0] iv, input logic [31:0] tv);
    chk({tag, ".busy"},     busy_s[0], b);
    chk({tag, ".done"},     done_s[0], d);
    chk({tag, ".id_ok"},    idok_s[0], io);
    chk({tag, ".ts_ok"},    tsok_s[0], tk);
    chk({tag, ".mismatch"}, mm_s[0],   mm);
    chk({tag, ".timeout"},  to_s[0],   tmo);
    chk({tag, ".id_value"}, idv_s[0],  iv);
    chk({tag, ".ts_value"}, tsv_s[0],  tv);
  endtask

  // Counts edges until done is seen (bounded); a missed done shows up in the
  // following done/edge comparisons.
  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (done_s[0]) break;
    end
  endtask

  // One-cycle start pulse on the main DUT; returns 1 ns after the sampling edge.
  task automatic pulse_start();
    @(negedge clk);
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
  endtask

  initial begin
    int edges;
    int a0;
    int s0;
    int busy_hi;

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i]  = 1'b0;
      mem_id[i]   = EXP_ID;
      mem_ts[i]   = EXP_TS;
      ws_n[i]     = (i == 0) ? 8'd0 : 8'd2;
      stuck_ts[i] = 1'b0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk_status("reset", 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    chk("reset.avm_read", rd_s[0], 1'b0);
    chk("reset.avm_address", addr_s[0], 1'b0);

    // Automatic check after reset release, matching words.
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("auto.busy_rise", busy_s[0], 1'b1);
    wait_done(50, edges);
    chk("auto.edges", edges, 6);
    chk_status("auto", 0, 1, 1, 1, 0, 0, EXP_ID, EXP_TS);
    chk("auto.reads", acc_cnt, 2);
    chk("auto.addr_seq", {30'd0, addr_seq[1:0]}, 32'd1);

    // Latency 0 and 3 builds with 2 wait states per read.
    for (int i = 0; i < 40; i++) begin
      if (done_s[1] && done_s[2]) break;
      @(negedge clk);
    end
    chk("lat0.edges", g_dut[1].be, 8);
    chk("lat0.id_value", idv_s[1], EXP_ID);
    chk("lat0.ts_value", tsv_s[1], EXP_TS);
    chk("lat0.ok", {30'd0, idok_s[1], tsok_s[1]}, 32'd3);
    chk("lat0.mismatch", mm_s[1], 1'b0);
    chk("lat3.edges", g_dut[2].be, 14);
    chk("lat3.id_value", idv_s[2], EXP_ID);
    chk("lat3.ts_value", tsv_s[2], EXP_TS);
    chk("lat3.ok", {30'd0, idok_s[2], tsok_s[2]}, 32'd3);
    chk("lat3.mismatch", mm_s[2], 1'b0);

    // Wrong timestamp (zero) from a start pulse in DONE.
    mem_ts[0] = 32'd0;
    a0 = acc_cnt;
    pulse_start();
    chk("ts0.busy", busy_s[0], 1'b1);
    chk("ts0.done_cleared", done_s[0], 1'b0);
    wait_done(50, edges);
    chk("ts0.edges", edges, 6);
    chk_status("ts0", 0, 1, 1, 0, 1, 0, EXP_ID, 32'd0);
    chk("ts0.reads", acc_cnt - a0, 2);

    // Wrong ID, with an extra start pulse while busy that must be ignored.
    mem_ts[0] = EXP_TS;
    mem_id[0] = 32'h12345678;
    a0 = acc_cnt;
    pulse_start();
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    // Edge after start already spent, so 5 of the 6 edges remain.
    wait_done(50, edges);
    chk("id_bad.edges", edges, 5);
    chk_status("id_bad", 0, 1, 0, 1, 1, 0, 32'h12345678, EXP_TS);
    repeat (10) @(negedge clk);
    chk("id_bad.busy_after", busy_s[0], 1'b0);
    chk("id_bad.done_held", done_s[0], 1'b1);
    chk("id_bad.reads", acc_cnt - a0, 2);

    // Stuck waitrequest on the timestamp read: 255 stalled cycles, then abort.
    mem_id[0]   = EXP_ID;
    stuck_ts[0] = 1'b1;
    a0 = acc_cnt;
    s0 = stall_cnt;
    pulse_start();
    wait_done(400, edges);
    // ID read 2 edges, 255 stalled edges, 1 edge to raise done.
    chk("tmo.edges", edges, 258);
    chk_status("tmo", 0, 1, 0, 0, 0, 1, EXP_ID, 32'd0);
    chk("tmo.stalls", stall_cnt - s0, 255);
    chk("tmo.avm_read", rd_s[0], 1'b0);
    chk("tmo.reads", acc_cnt - a0, 1);
    stuck_ts[0] = 1'b0;

    // Asynchronous reset while in WAIT_TS, then a fresh automatic check.
    pulse_start();
    repeat (3) @(posedge clk);
    #2;
    chk("midrst.pre_id_value", idv_s[0], EXP_ID);
    chk("midrst.pre_busy", busy_s[0], 1'b1);
    reset_n = 1'b0;
    #1;
    chk_status("midrst", 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    chk("midrst.avm_read", rd_s[0], 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rerun.busy_rise", busy_s[0], 1'b1);
    wait_done(50, edges);
    chk("rerun.edges", edges, 6);
    chk_status("rerun", 0, 1, 1, 1, 0, 0, EXP_ID, EXP_TS);

    // Without the periodic feature no check starts on its own.
    busy_hi = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy_s[0]) busy_hi++;
    end
    chk("idle.busy_cycles", busy_hi, 0);
    chk("idle.done_held", done_s[0], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
